parking_gate_arbiter: RTL and testbench

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

---
 rtl/parking_gate_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - seven-slot parking lot entry/exit arbiter with passcode check and gate timer
//
// Ports:
//   enable           clock, all state updates on its rising edge
//   gl_reset         synchronous active-low reset
//   entry_req        car waiting at the entry gate (level, held until entry_ack)
//   exit_req         car waiting at the exit gate (level, held until exit_ack/exit_err)
//   exit_from        slot 1..7 claimed by the exiting car, sampled with exit_req
//   exit_code        passcode presented by the exiting car, sampled with exit_req
//   entry_ack        one-cycle pulse, entry granted
//   entry_slot       assigned slot while entry_ack=1, else 0
//   entry_code       passcode of the assigned slot while entry_ack=1, else 0
//   exit_ack         one-cycle pulse, exit accepted
//   exit_err         one-cycle pulse, exit rejected
//   gate_open        gate actuator drive, high GATE_CYCLES cycles after an ack
//   occupancy        bit k-1 set when slot k is occupied
//   available_slots  number of free slots, 0..7
//   can_park         high when available_slots != 0
//   busy             high whenever the FSM is not idle
module parking_gate_arbiter #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       enable,
    input  logic       gl_reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_from,
    input  logic [7:0] exit_code,
    output logic       entry_ack,
    output logic [2:0] entry_slot,
    output logic [7:0] entry_code,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_open,
    output logic [6:0] occupancy,
    output logic [2:0] available_slots,
    output logic       can_park,
    output logic       busy
);

    localparam int CW = $clog2(GATE_CYCLES + 1);
    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IN  = 2'd1,
        GRANT_OUT = 2'd2,
        GATE      = 2'd3
    } state_t;

    // Slot k passcode: running sum of 1,2,3,5,8,13,21,34 over its first k+1 terms.
    function automatic logic [7:0] slot_code(input logic [2:0] slot);
        case (slot)
            3'd1:    slot_code = 8'd3;
            3'd2:    slot_code = 8'd6;
            3'd3:    slot_code = 8'd11;
            3'd4:    slot_code = 8'd19;
            3'd5:    slot_code = 8'd32;
            3'd6:    slot_code = 8'd53;
            3'd7:    slot_code = 8'd87;
            default: slot_code = 8'd0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   gate_cnt_q, gate_cnt_d;
    logic            prio_exit_q, prio_exit_d;
    logic [2:0]      from_q, from_d;
    logic [7:0]      code_q, code_d;
    logic [6:0]      occupancy_d;
    logic [2:0]      available_d;
    logic            can_park_d;
    logic            entry_ack_d;
    logic [2:0]      entry_slot_d;
    logic [7:0]      entry_code_d;
    logic            exit_ack_d;
    logic            exit_err_d;
    logic            gate_open_d;
    logic            busy_d;
    logic            entry_ok;
    logic            exit_valid;
    logic [2:0]      free_slot;
    logic [2:0]      used_count;

    always_ff @(posedge enable) begin
        if (!gl_reset) begin
            state_q         <= IDLE;
            gate_cnt_q      <= '0;
            prio_exit_q     <= 1'b1;
            from_q          <= 3'd0;
            code_q          <= 8'd0;
            occupancy       <= 7'd0;
            available_slots <= 3'd7;
            can_park        <= 1'b1;
            entry_ack       <= 1'b0;
            entry_slot      <= 3'd0;
            entry_code      <= 8'd0;
            exit_ack        <= 1'b0;
            exit_err        <= 1'b0;
            gate_open       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            gate_cnt_q      <= gate_cnt_d;
            prio_exit_q     <= prio_exit_d;
            from_q          <= from_d;
            code_q          <= code_d;
            occupancy       <= occupancy_d;
            available_slots <= available_d;
            can_park        <= can_park_d;
            entry_ack       <= entry_ack_d;
            entry_slot      <= entry_slot_d;
            entry_code      <= entry_code_d;
            exit_ack        <= exit_ack_d;
            exit_err        <= exit_err_d;
            gate_open       <= gate_open_d;
            busy            <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        prio_exit_d  = prio_exit_q;
        from_d       = from_q;
        code_d       = code_q;
        occupancy_d  = occupancy;
        entry_ack_d  = 1'b0;
        entry_slot_d = 3'd0;
        entry_code_d = 8'd0;
        exit_ack_d   = 1'b0;
        exit_err_d   = 1'b0;
        gate_open_d  = 1'b0;
        free_slot    = 3'd0;
        used_count   = 3'd0;

        // A full lot leaves entry_req pending rather than rejecting it.
        entry_ok = entry_req && (available_slots != 3'd0);

        // Ascending scan so the highest-numbered free slot wins.
        for (int k = 1; k <= 7; k++) begin
            if (!occupancy[k-1]) begin
                free_slot = 3'(k);
            end
        end

        exit_valid = (from_q != 3'd0) && occupancy[from_q - 3'd1] &&
                     (code_q == slot_code(from_q));

        case (state_q)
            IDLE: begin
                // Priority only flips when the favoured side is the one served.
                if (exit_req && (!entry_ok || prio_exit_q)) begin
                    from_d  = exit_from;
                    code_d  = exit_code;
                    state_d = GRANT_OUT;
                    if (prio_exit_q) begin
                        prio_exit_d = 1'b0;
                    end
                end else if (entry_ok) begin
                    state_d = GRANT_IN;
                    if (!prio_exit_q) begin
                        prio_exit_d = 1'b1;
                    end
                end
            end
            GRANT_IN: begin
                occupancy_d[free_slot - 3'd1] = 1'b1;
                entry_ack_d  = 1'b1;
                entry_slot_d = free_slot;
                entry_code_d = slot_code(free_slot);
                gate_cnt_d   = '0;
                state_d      = GATE;
            end
            GRANT_OUT: begin
                if (exit_valid) begin
                    occupancy_d[from_q - 3'd1] = 1'b0;
                    exit_ack_d = 1'b1;
                    gate_cnt_d = '0;
                    state_d    = GATE;
                end else begin
                    exit_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            GATE: begin
                // Entered on the ack edge; gate rises one edge later and stays
                // high for GATE_CYCLES cycles before returning to IDLE.
                if (gate_cnt_q == GATE_LAST) begin
                    state_d = IDLE;
                end else begin
                    gate_open_d = 1'b1;
                    gate_cnt_d  = gate_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int k = 0; k < 7; k++) begin
            used_count = used_count + {2'b00, occupancy_d[k]};
        end
        available_d = 3'd7 - used_count;
        can_park_d  = (available_d != 3'd0);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - scoreboard bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

    logic       enable = 1'b0;
    logic       gl_reset = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_from = 3'd0;
    logic [7:0] exit_code = 8'd0;
    logic       entry_ack;
    logic [2:0] entry_slot;
    logic [7:0] entry_code;
    logic       exit_ack;
    logic       exit_err;
    logic       gate_open;
    logic [6:0] occupancy;
    logic [2:0] available_slots;
    logic       can_park;
    logic       busy;

    parking_gate_arbiter #(.GATE_CYCLES(4)) dut (
        .enable(enable),
        .gl_reset(gl_reset),
        .entry_req(entry_req),
        .exit_req(exit_req),
        .exit_from(exit_from),
        .exit_code(exit_code),
        .entry_ack(entry_ack),
        .entry_slot(entry_slot),
        .entry_code(entry_code),
        .exit_ack(exit_ack),
        .exit_err(exit_err),
        .gate_open(gate_open),
        .occupancy(occupancy),
        .available_slots(available_slots),
        .can_park(can_park),
        .busy(busy)
    );

    always #5 enable = ~enable;

    localparam int K_ENTRY = 0;
    localparam int K_EXIT_ACK = 1;
    localparam int K_EXIT_ERR = 2;

    typedef struct {
        int         kind;
        logic [2:0] slot;
        logic [7:0] code;
        logic [6:0] occ;
        logic [2:0] avail;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;
    int   gate_len = 0;
    int   gate_runs = 0;
    bit   gate_abort = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [2:0] slot, input logic [7:0] code,
                        input logic [6:0] occ, input logic [2:0] avail);
        exp_t e;
        e.kind = kind;
        e.slot = slot;
        e.code = code;
        e.occ = occ;
        e.avail = avail;
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every response pulse and times gate runs.
    always @(negedge enable) begin
        exp_t e;
        logic [2:0] act_kind;
        logic [2:0] req_kind;
        if (entry_ack === 1'b1 || exit_ack === 1'b1 || exit_err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_response", {29'd0, entry_ack, exit_ack, exit_err}, 0);
            end else begin
                e = sb.pop_front();
                act_kind = {entry_ack, exit_ack, exit_err};
                req_kind = (e.kind == K_ENTRY) ? 3'b100 : (e.kind == K_EXIT_ACK) ? 3'b010 : 3'b001;
                check("response_kind", act_kind, req_kind);
                check("entry_slot", entry_slot, e.slot);
                check("entry_code", entry_code, e.code);
                check("occupancy", occupancy, e.occ);
                check("available_slots", available_slots, e.avail);
                check("can_park", can_park, e.avail != 3'd0);
            end
        end
        if (gate_open === 1'b1) begin
            gate_len++;
        end else if (gate_len != 0) begin
            if (gate_abort) begin
                gate_abort = 0;
            end else begin
                check("gate_open_length", gate_len, 4);
            end
            gate_runs++;
            gate_len = 0;
        end
    end

    task automatic wait_entry();
        int n = 0;
        do begin
            @(negedge enable);
            n++;
        end while (entry_ack !== 1'b1 && n < 60);
        if (entry_ack !== 1'b1) check("entry_ack_timeout", 0, 1);
    endtask

    task automatic wait_exit();
        int n = 0;
        do begin
            @(negedge enable);
            n++;
        end while (exit_ack !== 1'b1 && exit_err !== 1'b1 && n < 60);
        if (exit_ack !== 1'b1 && exit_err !== 1'b1) check("exit_resp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge enable);
            n++;
        end while ((busy !== 1'b0 || gate_open !== 1'b0) && n < 100);
        if (busy !== 1'b0 || gate_open !== 1'b0) check("idle_timeout", 0, 1);
        @(negedge enable);
    endtask

    task automatic do_entry(input logic [2:0] slot, input logic [7:0] code,
                            input logic [6:0] occ, input logic [2:0] avail);
        push(K_ENTRY, slot, code, occ, avail);
        entry_req = 1'b1;
        wait_entry();
        entry_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_exit(input logic [2:0] from, input logic [7:0] code, input int kind,
                           input logic [6:0] occ, input logic [2:0] avail);
        push(kind, 3'd0, 8'd0, occ, avail);
        exit_from = from;
        exit_code = code;
        exit_req = 1'b1;
        wait_exit();
        exit_req = 1'b0;
        wait_idle();
    endtask

    task automatic contend(input logic [2:0] from, input logic [7:0] code);
        exit_from = from;
        exit_code = code;
        entry_req = 1'b1;
        exit_req = 1'b1;
        fork
            begin
                wait_entry();
                entry_req = 1'b0;
            end
            begin
                wait_exit();
                exit_req = 1'b0;
            end
        join
        wait_idle();
    endtask

    logic [2:0] fill_slot [7] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    logic [7:0] fill_code [7] = '{8'd87, 8'd53, 8'd32, 8'd19, 8'd11, 8'd6, 8'd3};
    logic [6:0] fill_occ  [7] = '{7'b1000000, 7'b1100000, 7'b1110000, 7'b1111000,
                                  7'b1111100, 7'b1111110, 7'b1111111};
    logic [2:0] fill_av   [7] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        int seen;
        int runs_before;

        // Reset state after one reset edge
        gl_reset = 1'b0;
        @(negedge enable);
        check("rst_available", available_slots, 7);
        check("rst_occupancy", occupancy, 0);
        check("rst_can_park", can_park, 1);
        check("rst_gate_open", gate_open, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {entry_ack, exit_ack, exit_err}, 0);
        check("rst_entry_slot", entry_slot, 0);
        check("rst_entry_code", entry_code, 0);
        gl_reset = 1'b1;
        @(negedge enable);

        // Fill the lot, slots 7 down to 1
        for (int i = 0; i < 7; i++) begin
            do_entry(fill_slot[i], fill_code[i], fill_occ[i], fill_av[i]);
        end
        check("full_available", available_slots, 0);
        check("full_can_park", can_park, 0);

        // Entry on a full lot stays pending without any activity
        entry_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge enable);
            if (busy !== 1'b0) seen++;
        end
        entry_req = 1'b0;
        check("full_pending_busy_cycles", seen, 0);
        @(negedge enable);

        // Valid exit, then wrong passcode, slot 0 and empty slot
        do_exit(3'd6, 8'd53, K_EXIT_ACK, 7'b1011111, 3'd1);
        runs_before = gate_runs;
        push(K_EXIT_ERR, 3'd0, 8'd0, 7'b1011111, 3'd1);
        exit_from = 3'd5;
        exit_code = 8'd52;
        exit_req = 1'b1;
        wait_exit();
        exit_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge enable);
            if (gate_open !== 1'b0) seen++;
        end
        check("err_gate_cycles", seen, 0);
        check("err_gate_runs", gate_runs, runs_before);
        do_exit(3'd0, 8'd0, K_EXIT_ERR, 7'b1011111, 3'd1);
        do_exit(3'd6, 8'd53, K_EXIT_ERR, 7'b1011111, 3'd1);
        do_entry(3'd6, 8'd53, 7'b1111111, 3'd0);

        // Full lot contention: exit first, entry then gets the freed slot
        push(K_EXIT_ACK, 3'd0, 8'd0, 7'b1111011, 3'd1);
        push(K_ENTRY, 3'd3, 8'd11, 7'b1111111, 3'd0);
        contend(3'd3, 8'd11);

        // Reset during the second gate cycle
        push(K_EXIT_ACK, 3'd0, 8'd0, 7'b1111110, 3'd1);
        exit_from = 3'd1;
        exit_code = 8'd3;
        exit_req = 1'b1;
        wait_exit();
        exit_req = 1'b0;
        @(negedge enable);
        check("gate_first_cycle", gate_open, 1);
        @(negedge enable);
        gate_abort = 1;
        gl_reset = 1'b0;
        @(negedge enable);
        gl_reset = 1'b1;
        check("midgate_gate_open", gate_open, 0);
        check("midgate_available", available_slots, 7);
        check("midgate_occupancy", occupancy, 0);
        check("midgate_busy", busy, 0);
        check("midgate_can_park", can_park, 1);
        @(negedge enable);

        // Priority alternation with both sides eligible
        do_entry(3'd7, 8'd87, 7'b1000000, 3'd6);
        do_entry(3'd6, 8'd53, 7'b1100000, 3'd5);
        push(K_EXIT_ACK, 3'd0, 8'd0, 7'b1000000, 3'd6);
        push(K_ENTRY, 3'd6, 8'd53, 7'b1100000, 3'd5);
        contend(3'd6, 8'd53);
        do_exit(3'd6, 8'd53, K_EXIT_ACK, 7'b1000000, 3'd6);
        push(K_ENTRY, 3'd6, 8'd53, 7'b1100000, 3'd5);
        push(K_EXIT_ACK, 3'd0, 8'd0, 7'b0100000, 3'd6);
        contend(3'd7, 8'd87);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d required %0d", total, 0);
        $fatal(1, "timeout");
    end

endmodule
